jtag_cpu_biu: RTL and testbench

JTAG_CPU_BIU -- requirements
Module: jtag_cpu_biu

---
 rtl/jtag_cpu_biu.sv | 225 ++++++++++++++++++++++
 tb/tb_jtag_cpu_biu.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_cpu_biu.sv
// Bridges JTAG-side burst commands to single-beat bus accesses, with byte-lane steering.
// Latency: read command reaches bus_req_o 2 cycles after acceptance; ack shows on rdata_o 1 cycle later.
// Backpressure: one access in flight; waits on wdata_valid_i / rdata_ready_i; cmd_ready_o only in IDLE.
module jtag_cpu_biu #(
  parameter int TIMEOUT = 255  // must be >= 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_opcode_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [15:0] cmd_count_i,
  input  logic [31:0] wdata_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  input  logic        rdata_ready_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_WDATA,
    S_BUS,
    S_WAIT_RCONS,
    S_DONE
  } state_t;

  // Timeout counter counts completed bus cycles; the access gives up on cycle TIMEOUT.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          err_set;

  // Opcode decode: bit 2 clear means write, bits [1:0] give 1/2/4-byte size.
  logic        is_write;
  logic        op_legal;
  logic        misaligned;
  logic [31:0] addr_step;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] rd_ext;

  assign is_write   = ~op_q[2];
  assign op_legal   = ~op_q[3] & (op_q[1:0] != 2'b00);
  assign misaligned = ((op_q[1:0] == 2'd2) & addr_q[0]) |
                      ((op_q[1:0] == 2'd3) & (addr_q[1:0] != 2'b00));

  // Lane steering: write data replicated onto the addressed lanes, read data right-aligned.
  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = wdata_q;
    rd_ext     = bus_rdata_i;
    addr_step  = 32'd4;
    case (op_q[1:0])
      2'd1: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
        rd_ext     = {24'h0, bus_rdata_i[{addr_q[1:0], 3'b000} +: 8]};
        addr_step  = 32'd1;
      end
      2'd2: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
        rd_ext     = {16'h0, (addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0])};
        addr_step  = 32'd2;
      end
      2'd3: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        rd_ext     = bus_rdata_i;
        addr_step  = 32'd4;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = wdata_q;
        rd_ext     = bus_rdata_i;
        addr_step  = 32'd4;
      end
    endcase
  end

  // Next-state and datapath updates; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_opcode_i;
          addr_d  = cmd_addr_i;
          cnt_d   = cmd_count_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!op_legal || (cnt_q == 16'd0) || misaligned) begin
          err_set = 1'b1;
          state_d = S_DONE;
        end else if (is_write) begin
          state_d = S_WAIT_WDATA;
        end else begin
          tmo_d   = '0;
          state_d = S_BUS;
        end
      end
      S_WAIT_WDATA: begin
        if (wdata_valid_i) begin
          wdata_d = wdata_i;
          tmo_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (bus_ack_i) begin
          addr_d = addr_q + addr_step;
          cnt_d  = cnt_q - 16'd1;
          if (is_write) begin
            state_d = (cnt_q == 16'd1) ? S_DONE : S_WAIT_WDATA;
          end else begin
            rdata_d = rd_ext;
            state_d = S_WAIT_RCONS;
          end
        end else if (bus_err_i || (tmo_q == TMO_LAST)) begin
          err_set = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_RCONS: begin
        // Count was already decremented on the ack, so zero means this was the last beat.
        if (rdata_ready_i) begin
          if (cnt_q == 16'd0) begin
            state_d = S_DONE;
          end else begin
            tmo_d   = '0;
            state_d = S_BUS;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_set = 1'b0;
    end
  end

  // Sticky error: a set in the same cycle as a clear wins.
  always_comb begin
    err_d = err_set | (err_q & ~err_clr_i);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      cnt_q   <= 16'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign wdata_ready_o = (state_q == S_WAIT_WDATA);
  assign rdata_valid_o = (state_q == S_WAIT_RCONS);
  assign rdata_o       = rdata_q;
  assign bus_req_o     = (state_q == S_BUS);
  assign bus_we_o      = bus_req_o & is_write;
  assign bus_be_o      = bus_req_o ? lane_be : 4'b0000;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = lane_wdata;

endmodule

// File: tb/tb_jtag_cpu_biu.sv
// Bench for jtag_cpu_biu: random and directed bursts against a byte-memory slave and burst-level model.
// Latency: cycle-stepped; inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: random wdata_valid_i / rdata_ready_i gaps and random slave ack latency.
module tb_jtag_cpu_biu;

  localparam int TMO = 255;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [3:0]  cmd_opcode_i = 4'h0;
  logic [31:0] cmd_addr_i = 32'h0;
  logic [15:0] cmd_count_i = 16'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        wdata_valid_i = 1'b0;
  logic        wdata_ready_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        rdata_ready_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic        err_clr_i = 1'b0;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;

  jtag_cpu_biu #(.TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_opcode_i(cmd_opcode_i),
    .cmd_addr_i(cmd_addr_i), .cmd_count_i(cmd_count_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] last_rd;
  logic [31:0] wwords [16];
  logic [7:0]  mem [logic [31:0]];
  logic [3:0]  ops [6] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Byte-addressed memory; untouched bytes read as a fixed hash of their address.
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5C;
  endfunction

  // Little-endian value of `size` bytes starting at a.
  function automatic logic [31:0] exp_rd(input logic [31:0] a, input int size);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < size; k++) v[8*k +: 8] = mem_rd(a + 32'(k));
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input int size);
    logic [3:0] b = 4'h0;
    for (int k = 0; k < size; k++) b[int'(a[1:0]) + k] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] a, input int size, input logic [31:0] w);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < size; k++) v[8*(int'(a[1:0]) + k) +: 8] = w[8*k +: 8];
    return v;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = 32'h0;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = {8{be[j]}};
    return m;
  endfunction

  function automatic int op_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd5) return 1;
    if (op == 4'd2 || op == 4'd6) return 2;
    return 4;
  endfunction

  task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [15:0] c);
    cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_addr_i = a; cmd_count_i = c;
    step();
    cmd_valid_i = 1'b0; cmd_opcode_i = 4'($urandom); cmd_addr_i = $urandom; cmd_count_i = 16'($urandom);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !bus_req_o; i++) step();
    chk(tag, bus_req_o, 1);
  endtask

  // One complete burst with a responding slave; expectations derived from the burst's parameters.
  task automatic run_burst(input logic [3:0] op, input logic [31:0] base, input logic [15:0] cnt,
                           input int err_at, input bit no_ack, input int fix_lat);
    int size, n_exp_req, n_exp_rd, n_req, n_rd, req_cyc, run_len, lat, w_idx, cur;
    bit wr, legal, err_hit, exp_err, fin;
    logic [31:0] a, ra;
    size    = op_size(op);
    wr      = (op < 4'd4);
    legal   = (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7}) && (cnt != 16'd0) &&
              !(size == 2 && base[0]) && !(size == 4 && base[1:0] != 2'b00);
    err_hit = legal && !no_ack && err_at >= 0 && err_at < int'(cnt);
    if (!legal)       n_exp_req = 0;
    else if (no_ack)  n_exp_req = 1;
    else if (err_hit) n_exp_req = err_at + 1;
    else              n_exp_req = int'(cnt);
    n_exp_rd = (!legal || wr || no_ack) ? 0 : (err_hit ? err_at : int'(cnt));
    exp_err  = !legal || no_ack || err_hit;

    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk("err_cleared", err_o, 0);
    chk("cmd_ready_idle", cmd_ready_o, 1);
    send_cmd(op, base, cnt);
    chk("cmd_ready_busy", cmd_ready_o, 0);
    chk("busy_after_cmd", busy_o, 1);

    n_req = 0; n_rd = 0; req_cyc = 0; run_len = 0; w_idx = 0; fin = 0; lat = 0; cur = 0; a = 0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
      wdata_valid_i = 1'b0; wdata_i = $urandom; rdata_ready_i = 1'b0;
      if (done_o) begin
        fin = 1;
        chk("busy_in_done", busy_o, 1);
      end
      if (wdata_ready_o && w_idx < 16 && $urandom_range(0, 2) != 0) begin
        wdata_valid_i = 1'b1; wdata_i = wwords[w_idx]; w_idx++;
      end
      if (bus_req_o) begin
        run_len++;
        if (req_cyc == 0) begin
          cur = n_req; n_req++;
          lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
          a = base + 32'(cur * size);
          if (cur < n_exp_req) begin
            chk("bus_addr", bus_addr_o, a);
            chk("bus_be", bus_be_o, exp_be(a, size));
            chk("bus_we", bus_we_o, wr);
            if (wr) chk("bus_wdata", bus_wdata_o & lane_mask(exp_be(a, size)),
                        exp_wd(a, size, wwords[cur]));
          end
        end
        req_cyc++;
        if (!no_ack && req_cyc > lat) begin
          chk("bus_addr_hold", bus_addr_o, a);
          if (cur == err_at) begin
            bus_err_i = 1'b1;
          end else begin
            bus_ack_i = 1'b1;
            if (bus_we_o) begin
              for (int j = 0; j < 4; j++)
                if (bus_be_o[j]) mem[{bus_addr_o[31:2], 2'b00} + 32'(j)] = bus_wdata_o[8*j +: 8];
            end else begin
              bus_rdata_i = exp_rd({bus_addr_o[31:2], 2'b00}, 4);
            end
          end
          req_cyc = 0;
        end
      end else begin
        if (run_len > 0 && no_ack) chk("timeout_len", run_len, TMO);
        run_len = 0; req_cyc = 0;
      end
      if (rdata_valid_o) begin
        chk("no_req_while_rvalid", bus_req_o, 0);
        if ($urandom_range(0, 1) != 0) begin
          rdata_ready_i = 1'b1;
          ra = base + 32'(n_rd * size);
          chk("rdata", rdata_o, exp_rd(ra, size));
          last_rd = rdata_o;
          n_rd++;
        end
      end
      cmd_valid_i = !done_o && ($urandom_range(0, 3) == 0);
      step();
    end
    bus_ack_i = 1'b0; bus_err_i = 1'b0; rdata_ready_i = 1'b0; wdata_valid_i = 1'b0; cmd_valid_i = 1'b0;
    chk("burst_finished", fin, 1);
    chk("done_one_cycle", done_o, 0);
    chk("idle_ready", cmd_ready_o, 1);
    chk("idle_busy", busy_o, 0);
    chk("idle_req", bus_req_o, 0);
    chk("n_bus_req", n_req, n_exp_req);
    chk("n_rdata", n_rd, n_exp_rd);
    chk("err_result", err_o, exp_err);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] base;
    logic [15:0] cnt;
    int          s, e;

    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", bus_req_o, 0);
    chk("rst_be", bus_be_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_rvalid", rdata_valid_o, 0);
    chk("rst_wready", wdata_ready_o, 0);

    // Word read at 0 returning 0xDEADBEEF after a 3-cycle slave delay.
    mem[32'h0] = 8'hEF; mem[32'h1] = 8'hBE; mem[32'h2] = 8'hAD; mem[32'h3] = 8'hDE;
    run_burst(4'h7, 32'h0, 16'd1, -1, 1'b0, 3);
    chk("rd_word_value", last_rd, 32'hDEADBEEF);

    // Three byte writes from 0x1001; upper bits of each stream word are junk.
    wwords[0] = 32'h5555_55A1; wwords[1] = 32'hAAAA_AAB2; wwords[2] = 32'h1234_56C3;
    run_burst(4'h1, 32'h1001, 16'd3, -1, 1'b0, -1);
    chk("wr_byte_1001", mem_rd(32'h1001), 32'hA1);
    chk("wr_byte_1002", mem_rd(32'h1002), 32'hB2);
    chk("wr_byte_1003", mem_rd(32'h1003), 32'hC3);
    chk("wr_byte_1000_untouched", mem_rd(32'h1000), 32'h4C);

    // Misaligned half read is rejected without touching the bus.
    run_burst(4'h6, 32'h3, 16'd1, -1, 1'b0, -1);

    // Error set and clear in the same cycle keeps the error.
    send_cmd(4'h6, 32'h3, 16'd1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk("err_set_beats_clr", err_o, 1);
    chk("err_path_done", done_o, 1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk("err_clr_alone", err_o, 0);

    // Slave never answers: one request held for the full timeout, second access skipped.
    run_burst(4'h7, 32'h2000, 16'd2, -1, 1'b1, -1);

    // Bus error on the second byte read; remaining accesses skipped.
    run_burst(4'h5, 32'h30, 16'd4, 1, 1'b0, -1);

    // Word writes wrapping from the top of the address space.
    wwords[0] = $urandom; wwords[1] = $urandom;
    run_burst(4'h3, 32'hFFFF_FFFC, 16'd2, -1, 1'b0, -1);
    chk("wrap_low_byte", mem_rd(32'h0), 32'(wwords[1][7:0]));

    // Consumer stall holds read data and blocks the next access; abort then drops to IDLE.
    send_cmd(4'h7, 32'h100, 16'd4);
    wait_req("abort_req_seen");
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D; step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rvalid", rdata_valid_o, 1);
      chk("stall_rdata", rdata_o, 32'hCAFE_F00D);
      chk("stall_no_req", bus_req_o, 0);
      step();
    end
    abort_i = 1'b1; step(); abort_i = 1'b0;
    chk("abort_idle", busy_o, 0);
    chk("abort_ready", cmd_ready_o, 1);
    chk("abort_rvalid", rdata_valid_o, 0);
    chk("abort_no_done", done_o, 0);
    chk("abort_err_kept", err_o, 0);
    step();
    chk("abort_no_done_later", done_o, 0);

    // Abort wins over an ack in the same cycle.
    send_cmd(4'h7, 32'h200, 16'd2);
    wait_req("abort_ack_req_seen");
    bus_ack_i = 1'b1; abort_i = 1'b1; step();
    bus_ack_i = 1'b0; abort_i = 1'b0;
    chk("abort_ack_idle", busy_o, 0);
    chk("abort_ack_rvalid", rdata_valid_o, 0);
    chk("abort_ack_req", bus_req_o, 0);
    step();
    chk("abort_ack_no_done", done_o, 0);

    // Reset in the middle of a bus access.
    send_cmd(4'h7, 32'h300, 16'd1);
    wait_req("rst_mid_req_seen");
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_req_low", bus_req_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    chk("rst_mid_ready", cmd_ready_o, 1);
    chk("rst_mid_no_done", done_o, 0);
    chk("rst_mid_rvalid", rdata_valid_o, 0);

    // Random bursts, occasionally illegal, zero-length, misaligned, wrapping or errored.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
      else op = ops[$urandom_range(0, 5)];
      s = op_size(op);
      base = $urandom;
      if ($urandom_range(0, 5) == 0) base = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) base = base & ~32'(s - 1);
      cnt = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
      for (int i = 0; i < 16; i++) wwords[i] = $urandom;
      run_burst(op, base, cnt, e, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
